instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
- Front-end stage that feeds the decoder/control unit.
- Holds the PC and fetches 32-bit instructions from instruction memory over a req/ack handshake.
- Presents each instruction, its PC and its 7-bit opcode field to decode with a valid/ready handshake.
- Accepts branch redirects from execute and discards stale fetches.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- ADDR_WIDTH, 32, PC and memory address width.
- NOP_INSTR, 32'h0000_0013, instruction output value while no instruction is held (addi x0,x0,0).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; high while state==REQ.
- imem_addr  out  ADDR_WIDTH  fetch address (= pc); stable while imem_req high and no ack.
- imem_ack  in  1  one-cycle pulse; completes the current request; may arrive in the first req cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- branch_taken  in  1  redirect strobe from execute.
- branch_target  in  ADDR_WIDTH  redirect address.
- instr_valid  out  1  instruction/instr_pc are valid.
- instr_ready  in  1  decode accepts the instruction this cycle.
- instruction  out  32  held instruction word.
- instr_pc  out  ADDR_WIDTH  address of the held instruction.
- instruction_opcode  out  7  instruction[6:0], drives the control unit.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high (clk, reset).
- Reset values: pc=RESET_VECTOR, state=REQ, drop_pending=0, instr_valid=0, instruction=NOP_INSTR, instr_pc=0.
  - First imem_req is high in the first cycle after reset deasserts, with imem_addr=RESET_VECTOR.
  - Instruction memory shares the same reset; no ack is outstanding after reset.
  - Reset mid-request or mid-hold abandons everything.
- FSM states: REQ, OUT.
- REQ: imem_req=1, imem_addr=pc.
  - On imem_ack with drop_pending=0 and no branch_taken: instruction<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4, go to OUT.
  - pc+4 wraps modulo 2^ADDR_WIDTH.
- OUT: imem_req=0.
  - On instr_valid && instr_ready: instr_valid<=0, instruction<=NOP_INSTR, go to REQ.
  - Minimum fetch-to-fetch spacing is 2 cycles with a 0-wait ack.
- Redirect (branch_taken=1) has priority over ack and ready. pc<=branch_target and instr_valid<=0 in all cases; then:
  - In OUT: go to REQ.
  - In REQ, same cycle as imem_ack: response discarded, stay in REQ; the next cycle requests the target.
  - In REQ, no ack this cycle: drop_pending<=1. imem_addr stays at the old pc value latched for the outstanding request until its ack, which is discarded. Then drop_pending<=0 and the target is requested.
  - This requires an internal req_addr register separate from pc while drop_pending=1.
- Back-to-back redirects: the last one wins. drop_pending stays 1 until exactly one ack is consumed.
- instruction_opcode is purely combinational from instruction[6:0].
- instr_valid never drops without a handshake except on redirect or reset.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_misaligned (1 bit, reset 0).
  - A redirect with branch_target[1:0]!=0 sets fetch_misaligned=1, loads pc with the raw target, and blocks fetching (imem_req=0) while it remains set; any outstanding ack is still consumed and discarded.
  - It stays set until reset or the next aligned redirect, which clears it.
- Undefined: branch_target[1:0] is forced to 2'b00 on redirect; no extra port.

Test Plan:
- Reset with RESET_VECTOR=32'h100 → the first cycle after reset shows imem_req=1, imem_addr=32'h100; instr_valid=0, instruction=32'h13.
- 0-wait ack, rdata=32'h00500093, instr_ready=1 → instr_valid=1 next cycle, instr_pc=32'h100, instruction_opcode=7'b0010011; next request at 32'h104.
- instr_ready low for 5 cycles → instruction held stable, imem_req=0 throughout; fetch of 32'h108 starts the cycle after ready.
- Ack delayed 3 cycles; branch_taken with target 32'h200 in cycle 1 → imem_addr stays 32'h104 until the ack; that data is never presented; next request is at 32'h200.
- branch_taken in the same cycle as imem_ack → instr_valid stays 0; the next cycle requests the target. Also at pc=32'hFFFF_FFFC: ack → next addr 32'h0 (wrap).
- MISALIGN_CHECK_EN: target 32'h202 → fetch_misaligned=1, imem_req=0; then target 32'h300 → flag clears and 32'h300 is requested. Without the macro: target 32'h202 → request at 32'h200.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC holder and instruction fetcher with branch redirect; optional MISALIGN_CHECK_EN
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [31:0]           NOP_INSTR    = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    input  logic                  branch_taken,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [31:0]           instruction,
    output logic [ADDR_WIDTH-1:0] instr_pc,
`ifdef MISALIGN_CHECK_EN
    output logic                  fetch_misaligned,
`endif
    output logic [6:0]            instruction_opcode
);

    typedef enum logic {
        REQ = 1'b0,
        OUT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  drop_q, drop_d;
    logic                  valid_q, valid_d;
    logic [31:0]           instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
    logic                  fetch_en;
    logic [ADDR_WIDTH-1:0] redirect_pc;
`ifdef MISALIGN_CHECK_EN
    logic                  mis_q, mis_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= REQ;
            pc_q       <= RESET_VECTOR;
            req_addr_q <= RESET_VECTOR;
            drop_q     <= 1'b0;
            valid_q    <= 1'b0;
            instr_q    <= NOP_INSTR;
            ipc_q      <= '0;
`ifdef MISALIGN_CHECK_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
            instr_q    <= instr_d;
            ipc_q      <= ipc_d;
`ifdef MISALIGN_CHECK_EN
            mis_q      <= mis_d;
`endif
        end
    end

    // A misaligned PC blocks new fetches, but an already issued request stays up until its ack.
`ifdef MISALIGN_CHECK_EN
    assign fetch_en    = (state_q == REQ) && (!mis_q || drop_q);
    assign redirect_pc = branch_target;
`else
    assign fetch_en    = (state_q == REQ);
    assign redirect_pc = branch_target & ~ADDR_WIDTH'(3);
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        drop_d     = drop_q;
        valid_d    = valid_q;
        instr_d    = instr_q;
        ipc_d      = ipc_q;
`ifdef MISALIGN_CHECK_EN
        mis_d      = mis_q;
`endif
        if (branch_taken) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            state_d = REQ;
`ifdef MISALIGN_CHECK_EN
            mis_d   = |branch_target[1:0];
`endif
            if (fetch_en) begin
                if (imem_ack) begin
                    drop_d = 1'b0;
                end else begin
                    // Keep the address of the request already on the bus; only the first redirect latches it.
                    drop_d = 1'b1;
                    if (!drop_q) begin
                        req_addr_d = pc_q;
                    end
                end
            end
        end else begin
            case (state_q)
                REQ: begin
                    if (fetch_en && imem_ack) begin
                        if (drop_q) begin
                            drop_d = 1'b0;
                        end else begin
                            instr_d = imem_rdata;
                            ipc_d   = pc_q;
                            valid_d = 1'b1;
                            pc_d    = pc_q + ADDR_WIDTH'(4);
                            state_d = OUT;
                        end
                    end
                end
                OUT: begin
                    if (valid_q && instr_ready) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    assign imem_req           = fetch_en;
    assign imem_addr          = drop_q ? req_addr_q : pc_q;
    assign instr_valid        = valid_q;
    assign instruction        = instr_q;
    assign instr_pc           = ipc_q;
    assign instruction_opcode = instr_q[6:0];
`ifdef MISALIGN_CHECK_EN
    assign fetch_misaligned   = mis_q;
`endif

endmodule
